// File: rtl/mshr_rsp.sv
// mshr_rsp: response-side MSHR. Tracks accepted memory requests in allocation
// order, completes them out of order by memory tag, and hands finished fills
// to the D-cache in order through a valid/ack handshake.

package mshr_rsp_pkg;
  localparam int unsigned DCACHE_TAG_W        = 20;
  localparam int unsigned DCACHE_IDX_W        = 6;
  localparam int unsigned DCACHE_WORD_IN_BITS = 64;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    GET_S = 2'd1,
    GET_M = 2'd2,
    PUT_M = 2'd3
  } message_t;
endpackage

module mshr_rsp
  import mshr_rsp_pkg::*;
#(
  parameter int unsigned MSHR_NUM  = 4,
  parameter int unsigned MEM_TAG_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mshr_rsp_alloc_en_i,
  input  logic [DCACHE_TAG_W-1:0]        mshr_rsp_tag_i,
  input  logic [DCACHE_IDX_W-1:0]        mshr_rsp_idx_i,
  input  message_t                       mshr_rsp_message_i,
  input  logic                           mshr_rsp_stq_c_flag_i,
  input  logic [MEM_TAG_W-1:0]           mshr_rsp_mem_tag_i,
  input  logic [MEM_TAG_W-1:0]           mem2mshr_rsp_tag_i,
  input  logic [DCACHE_WORD_IN_BITS-1:0] mem2mshr_rsp_data_i,
  output logic                           mshr_rsp_fill_en_o,
  output logic [DCACHE_TAG_W-1:0]        mshr_rsp_fill_tag_o,
  output logic [DCACHE_IDX_W-1:0]        mshr_rsp_fill_idx_o,
  output logic [DCACHE_WORD_IN_BITS-1:0] mshr_rsp_fill_data_o,
  output message_t                       mshr_rsp_fill_message_o,
  output logic                           mshr_rsp_fill_stq_c_flag_o,
  input  logic                           mshr_rsp_fill_ack_i,
  input  logic [DCACHE_TAG_W-1:0]        lq2mshr_rsp_tag_i,
  input  logic [DCACHE_IDX_W-1:0]        lq2mshr_rsp_idx_i,
  output logic                           mshr_rsp_lq_hit_o,
  output logic                           mshr_rsp_orphan_o,
  output logic                           mshr_rsp_full_o,
  output logic                           mshr_rsp_empty_o
);

  localparam int unsigned PTR_W = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  // Entry storage
  logic [MSHR_NUM-1:0]            vld_q;
  logic [MSHR_NUM-1:0]            done_q;
  logic [MSHR_NUM-1:0]            stq_q;
  logic [DCACHE_TAG_W-1:0]        tag_q     [MSHR_NUM];
  logic [DCACHE_IDX_W-1:0]        idx_q     [MSHR_NUM];
  message_t                       msg_q     [MSHR_NUM];
  logic [MEM_TAG_W-1:0]           mem_tag_q [MSHR_NUM];
  logic [DCACHE_WORD_IN_BITS-1:0] data_q    [MSHR_NUM];

  // Pointers carry the wrap bit in their MSB
  logic [CNT_W-1:0] head_q, tail_q, count;
  logic [PTR_W-1:0] head_idx, tail_idx;

  logic                rsp_present;
  logic [MSHR_NUM-1:0] rsp_hit;
  logic                alloc_ok;
  logic                head_ready;
  logic                retire;

  assign head_idx    = head_q[PTR_W-1:0];
  assign tail_idx    = tail_q[PTR_W-1:0];
  assign count       = tail_q - head_q;
  assign rsp_present = (mem2mshr_rsp_tag_i != '0);

  assign mshr_rsp_full_o  = (count == CNT_W'(MSHR_NUM));
  assign mshr_rsp_empty_o = (head_q == tail_q);

  assign alloc_ok   = mshr_rsp_alloc_en_i & ~mshr_rsp_full_o;
  assign head_ready = vld_q[head_idx] & done_q[head_idx];
  assign retire     = head_ready & ((msg_q[head_idx] == PUT_M) | mshr_rsp_fill_ack_i);

  assign mshr_rsp_fill_en_o         = head_ready & (msg_q[head_idx] != PUT_M);
  assign mshr_rsp_fill_tag_o        = tag_q[head_idx];
  assign mshr_rsp_fill_idx_o        = idx_q[head_idx];
  assign mshr_rsp_fill_data_o       = data_q[head_idx];
  assign mshr_rsp_fill_message_o    = msg_q[head_idx];
  assign mshr_rsp_fill_stq_c_flag_o = stq_q[head_idx];

  // Response tag match and load-queue lookup against registered entries only
  always_comb begin
    rsp_hit           = '0;
    mshr_rsp_lq_hit_o = 1'b0;
    for (int i = 0; i < int'(MSHR_NUM); i++) begin
      rsp_hit[i] = rsp_present & vld_q[i] & ~done_q[i] &
                   (mem_tag_q[i] == mem2mshr_rsp_tag_i);
      if (vld_q[i] && !done_q[i] &&
          (msg_q[i] == GET_S || msg_q[i] == GET_M) &&
          tag_q[i] == lq2mshr_rsp_tag_i && idx_q[i] == lq2mshr_rsp_idx_i)
        mshr_rsp_lq_hit_o = 1'b1;
    end
    mshr_rsp_orphan_o = rsp_present & ~(|rsp_hit);
  end

  // Allocate at tail, complete by tag, retire at head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      done_q <= '0;
      stq_q  <= '0;
      for (int i = 0; i < int'(MSHR_NUM); i++) begin
        tag_q[i]     <= '0;
        idx_q[i]     <= '0;
        msg_q[i]     <= NONE;
        mem_tag_q[i] <= '0;
        data_q[i]    <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      for (int i = 0; i < int'(MSHR_NUM); i++) begin
        if (rsp_hit[i]) begin
          done_q[i] <= 1'b1;
          data_q[i] <= mem2mshr_rsp_data_i;
        end
      end
      if (alloc_ok) begin
        vld_q[tail_idx]     <= 1'b1;
        done_q[tail_idx]    <= (mshr_rsp_message_i == PUT_M);
        stq_q[tail_idx]     <= mshr_rsp_stq_c_flag_i;
        tag_q[tail_idx]     <= mshr_rsp_tag_i;
        idx_q[tail_idx]     <= mshr_rsp_idx_i;
        msg_q[tail_idx]     <= mshr_rsp_message_i;
        mem_tag_q[tail_idx] <= mshr_rsp_mem_tag_i;
        data_q[tail_idx]    <= '0;
        tail_q              <= tail_q + CNT_W'(1);
      end
      if (retire) begin
        vld_q[head_idx]     <= 1'b0;
        done_q[head_idx]    <= 1'b0;
        stq_q[head_idx]     <= 1'b0;
        tag_q[head_idx]     <= '0;
        idx_q[head_idx]     <= '0;
        msg_q[head_idx]     <= NONE;
        mem_tag_q[head_idx] <= '0;
        data_q[head_idx]    <= '0;
        head_q              <= head_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mshr_rsp.sv
// Scoreboard bench for mshr_rsp: stimulus pushes expected fills, a negedge
// monitor pops and compares them as the DUT presents them.
module tb_mshr_rsp;
  import mshr_rsp_pkg::*;

  localparam int unsigned TW = DCACHE_TAG_W;
  localparam int unsigned IW = DCACHE_IDX_W;
  localparam int unsigned DW = DCACHE_WORD_IN_BITS;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_en;
  logic [TW-1:0] a_tag;
  logic [IW-1:0] a_idx;
  message_t      a_msg;
  logic          a_stq;
  logic [3:0]    a_mtag;
  logic [3:0]    r_tag;
  logic [DW-1:0] r_data;
  logic          fill_en;
  logic [TW-1:0] fill_tag;
  logic [IW-1:0] fill_idx;
  logic [DW-1:0] fill_data;
  message_t      fill_msg;
  logic          fill_stq;
  logic          ack;
  logic [TW-1:0] lq_tag;
  logic [IW-1:0] lq_idx;
  logic          lq_hit, orphan, full, empty;

  typedef struct {
    logic [TW-1:0] tag;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    message_t      msg;
    logic          stq;
  } fill_t;

  fill_t sb[$];
  int    checks   = 0;
  int    failures = 0;
  logic  auto_ack = 1'b0;

  mshr_rsp #(.MSHR_NUM(4), .MEM_TAG_W(4)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .mshr_rsp_alloc_en_i        (alloc_en),
    .mshr_rsp_tag_i             (a_tag),
    .mshr_rsp_idx_i             (a_idx),
    .mshr_rsp_message_i         (a_msg),
    .mshr_rsp_stq_c_flag_i      (a_stq),
    .mshr_rsp_mem_tag_i         (a_mtag),
    .mem2mshr_rsp_tag_i         (r_tag),
    .mem2mshr_rsp_data_i        (r_data),
    .mshr_rsp_fill_en_o         (fill_en),
    .mshr_rsp_fill_tag_o        (fill_tag),
    .mshr_rsp_fill_idx_o        (fill_idx),
    .mshr_rsp_fill_data_o       (fill_data),
    .mshr_rsp_fill_message_o    (fill_msg),
    .mshr_rsp_fill_stq_c_flag_o (fill_stq),
    .mshr_rsp_fill_ack_i        (ack),
    .lq2mshr_rsp_tag_i          (lq_tag),
    .lq2mshr_rsp_idx_i          (lq_idx),
    .mshr_rsp_lq_hit_o          (lq_hit),
    .mshr_rsp_orphan_o          (orphan),
    .mshr_rsp_full_o            (full),
    .mshr_rsp_empty_o           (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare and ack each presented fill when acking is enabled
  always @(negedge clk) begin
    if (!rst && fill_en && auto_ack) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_fill: got tag %0h with empty scoreboard (t=%0t)", fill_tag, $time);
      end else begin
        fill_t e;
        e = sb.pop_front();
        chk("fill_tag",  64'(fill_tag),  64'(e.tag));
        chk("fill_idx",  64'(fill_idx),  64'(e.idx));
        chk("fill_data", 64'(fill_data), 64'(e.data));
        chk("fill_msg",  64'(fill_msg),  64'(e.msg));
        chk("fill_stq",  64'(fill_stq),  64'(e.stq));
      end
      ack = 1'b1;
    end else begin
      ack = 1'b0;
    end
  end

  task automatic push(input logic [TW-1:0] t, input logic [IW-1:0] i,
                      input logic [DW-1:0] d, input message_t m, input logic s);
    fill_t e;
    e.tag = t; e.idx = i; e.data = d; e.msg = m; e.stq = s;
    sb.push_back(e);
  endtask

  task automatic do_alloc(input logic [TW-1:0] t, input logic [IW-1:0] i,
                          input message_t m, input logic s, input logic [3:0] mt);
    alloc_en = 1'b1; a_tag = t; a_idx = i; a_msg = m; a_stq = s; a_mtag = mt;
    @(posedge clk); #1;
    alloc_en = 1'b0;
  endtask

  task automatic do_rsp(input logic [3:0] mt, input logic [DW-1:0] d,
                        input logic exp_orphan, input string name);
    r_tag = mt; r_data = d;
    #1 chk(name, 64'(orphan), 64'(exp_orphan));
    @(posedge clk); #1;
    r_tag = '0;
  endtask

  // Bounded wait until all expected fills are consumed and nothing is presented
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || fill_en) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; alloc_en = 1'b0; a_tag = '0; a_idx = '0; a_msg = NONE;
    a_stq = 1'b0; a_mtag = '0; r_tag = '0; r_data = '0; lq_tag = '0; lq_idx = '0;
    ack = 1'b0;
    #1;
    chk("rst_fill_en",  64'(fill_en),   64'd0);
    chk("rst_fill_tag", 64'(fill_tag),  64'd0);
    chk("rst_fill_dat", 64'(fill_data), 64'd0);
    chk("rst_fill_msg", 64'(fill_msg),  64'(NONE));
    chk("rst_full",     64'(full),      64'd0);
    chk("rst_empty",    64'(empty),     64'd1);
    chk("rst_lq_hit",   64'(lq_hit),    64'd0);
    chk("rst_orphan",   64'(orphan),    64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // In-order GET_S
    auto_ack = 1'b1;
    do_alloc(20'h12, 6'd5, GET_S, 1'b0, 4'd3);
    push(20'h12, 6'd5, 64'hDEADBEEF, GET_S, 1'b0);
    do_rsp(4'd3, 64'hDEADBEEF, 1'b0, "io_orphan");
    chk("io_fill_en_n1", 64'(fill_en), 64'd1);
    wait_drain("io_drain");
    chk("io_empty", 64'(empty), 64'd1);

    // Out-of-order completion, fills held until acked
    auto_ack = 1'b0;
    do_alloc(20'h21, 6'd1, GET_S, 1'b0, 4'd1);
    do_alloc(20'h22, 6'd2, GET_M, 1'b1, 4'd2);
    push(20'h21, 6'd1, 64'h1111, GET_S, 1'b0);
    push(20'h22, 6'd2, 64'h2222, GET_M, 1'b1);
    do_rsp(4'd2, 64'h2222, 1'b0, "ooo_rsp2");
    chk("ooo_no_fill", 64'(fill_en), 64'd0);
    do_rsp(4'd1, 64'h1111, 1'b0, "ooo_rsp1");
    repeat (3) @(posedge clk);
    #1;
    chk("ooo_hold_en",  64'(fill_en),  64'd1);
    chk("ooo_hold_tag", 64'(fill_tag), 64'h21);
    auto_ack = 1'b1;
    wait_drain("ooo_drain");
    chk("ooo_empty", 64'(empty), 64'd1);

    // PUT_M retires silently ahead of a GET_M
    lq_tag = 20'h31; lq_idx = 6'd4;
    do_alloc(20'h30, 6'd3, PUT_M, 1'b0, 4'd0);
    chk("put_no_fill", 64'(fill_en), 64'd0);
    do_alloc(20'h31, 6'd4, GET_M, 1'b0, 4'd4);
    chk("put_lq_hit", 64'(lq_hit), 64'd1);
    @(posedge clk); #1;
    chk("put_retired_empty", 64'(empty), 64'd0);
    chk("put_full", 64'(full), 64'd0);
    push(20'h31, 6'd4, 64'h4444, GET_M, 1'b0);
    do_rsp(4'd4, 64'h4444, 1'b0, "put_rsp");
    chk("put_lq_miss", 64'(lq_hit), 64'd0);
    wait_drain("put_drain");
    chk("put_empty", 64'(empty), 64'd1);
    lq_tag = '0; lq_idx = '0;

    // Full, ignored alloc, and pointer wrap
    auto_ack = 1'b0;
    for (int k = 0; k < 4; k++)
      do_alloc(TW'(32'h40 + k), IW'(k), GET_S, 1'b0, 4'(k + 1));
    chk("wrap_full", 64'(full), 64'd1);
    do_alloc(20'h44, 6'd9, GET_S, 1'b0, 4'd5);
    chk("wrap_full_kept", 64'(full), 64'd1);
    do_rsp(4'd5, 64'h5555, 1'b1, "wrap_ignored_orphan");
    push(20'h40, 6'd0, 64'hA1, GET_S, 1'b0);
    push(20'h41, 6'd1, 64'hA2, GET_S, 1'b0);
    auto_ack = 1'b1;
    do_rsp(4'd1, 64'hA1, 1'b0, "wrap_rsp1");
    do_rsp(4'd2, 64'hA2, 1'b0, "wrap_rsp2");
    wait_drain("wrap_drain1");
    chk("wrap_not_full", 64'(full), 64'd0);
    chk("wrap_not_empty", 64'(empty), 64'd0);
    do_alloc(20'h46, 6'd6, GET_M, 1'b1, 4'd6);
    do_alloc(20'h47, 6'd7, GET_S, 1'b0, 4'd7);
    chk("wrap_full2", 64'(full), 64'd1);
    push(20'h42, 6'd2, 64'hA3, GET_S, 1'b0);
    push(20'h43, 6'd3, 64'hA4, GET_S, 1'b0);
    push(20'h46, 6'd6, 64'hA6, GET_M, 1'b1);
    push(20'h47, 6'd7, 64'hA7, GET_S, 1'b0);
    do_rsp(4'd7, 64'hA7, 1'b0, "wrap_rsp7");
    do_rsp(4'd4, 64'hA4, 1'b0, "wrap_rsp4");
    do_rsp(4'd6, 64'hA6, 1'b0, "wrap_rsp6");
    do_rsp(4'd3, 64'hA3, 1'b0, "wrap_rsp3");
    wait_drain("wrap_drain2");
    chk("wrap_empty", 64'(empty), 64'd1);

    // Orphans: unknown tag, and response racing its own alloc
    do_rsp(4'd7, 64'h77, 1'b1, "orph_tag7");
    chk("orph_state", 64'(empty), 64'd1);
    lq_tag = 20'h55; lq_idx = 6'd5;
    alloc_en = 1'b1; a_tag = 20'h55; a_idx = 6'd5; a_msg = GET_S; a_stq = 1'b0; a_mtag = 4'd5;
    r_tag = 4'd5; r_data = 64'hBAD;
    #1 chk("same_cyc_orphan", 64'(orphan), 64'd1);
    @(posedge clk); #1;
    alloc_en = 1'b0; r_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("same_cyc_not_done", 64'(fill_en), 64'd0);
    chk("same_cyc_lq_hit", 64'(lq_hit), 64'd1);
    push(20'h55, 6'd5, 64'h5A5A, GET_S, 1'b0);
    do_rsp(4'd5, 64'h5A5A, 1'b0, "same_cyc_late_rsp");
    wait_drain("same_cyc_drain");
    lq_tag = '0; lq_idx = '0;

    // Asynchronous reset while a fill is presented
    auto_ack = 1'b0;
    do_alloc(20'h66, 6'd6, GET_S, 1'b0, 4'd3);
    do_rsp(4'd3, 64'h66, 1'b0, "rst_mid_rsp");
    chk("rst_mid_fill_before", 64'(fill_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_fill_en", 64'(fill_en), 64'd0);
    chk("rst_mid_empty", 64'(empty), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_rsp(4'd3, 64'h66, 1'b1, "rst_mid_orphan");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
